// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// The line is brought into the clock domain by a two-flop synchronizer.
// Start, data and stop bits are sampled mid-bit with a per-bit cycle
// counter. Good frames update out_data with a one-cycle out_data_en strobe.
// A low stop bit raises a one-cycle out_frame_err strobe, and the FSM then
// waits in BREAK until the line returns high, so a held-low line produces
// only one error.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_rx,
  output logic [7:0] out_data,
  output logic       out_data_en,
  output logic       out_frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchronizer flops. Both idle high, so reset does not look like a start.
  logic rx_meta_q;
  logic rx_s_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          data_en_q, data_en_d;
  logic          frame_err_q, frame_err_d;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= in_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      data_en_q   <= data_en_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic. Each strobe comes from a single branch, so the two
  // strobes are mutually exclusive by construction.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    data_en_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        // Re-check the line at the middle of the start bit to reject glitches.
        if (cnt_q == CNT_HALF_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        // LSB arrives first, so shift right and insert at the top.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        // Return to IDLE mid-stop-bit so a back-to-back start is caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d    = shift_q;
            data_en_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_data      = data_q;
  assign out_data_en   = data_en_q;
  assign out_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a scoreboard.
// The stimulus pushes one expected strobe (kind, value, cycle) per frame.
// A monitor pops one entry and compares it whenever the DUT raises a strobe.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // in_rx is driven on a falling edge. rx_s is low two rising edges later
  // (cycle T), and the strobe appears one cycle after the stop sample.
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] out_data;
  logic       out_data_en;
  logic       out_frame_err;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  logic [7:0] last_good;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_rx         (rx),
    .out_data      (out_data),
    .out_data_en   (out_data_en),
    .out_frame_err (out_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (out_data_en || out_frame_err)) begin
      checks = checks + 1;
      if (out_data_en && out_frame_err) begin
        errors = errors + 1;
        $display("FAIL exclusive: data_en=%0b frame_err=%0b both high, required one", out_data_en, out_frame_err);
      end
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_strobe: data_en=%0b frame_err=%0b data=0x%02h at cycle %0d, required none",
                 out_data_en, out_frame_err, out_data, cyc);
      end else begin
        e = sb_q.pop_front();
        $display("RX %s data=0x%02h cycle=%0d (expected %s 0x%02h cycle %0d)",
                 out_frame_err ? "frame_err" : "byte", out_data, cyc,
                 e.is_err ? "frame_err" : "byte", e.data, e.cyc);
        checks = checks + 3;
        if (out_frame_err !== e.is_err || out_data_en !== !e.is_err) begin
          errors = errors + 1;
          $display("FAIL strobe_kind: data_en=%0b frame_err=%0b, required frame_err=%0b",
                   out_data_en, out_frame_err, e.is_err);
        end
        if (out_data !== e.data) begin
          errors = errors + 1;
          $display("FAIL data_value: got 0x%02h, required 0x%02h", out_data, e.data);
        end
        if (cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL strobe_cycle: got %0d, required %0d", cyc, e.cyc);
        end
      end
    end
  end

  // Send one 8N1 frame, starting right after a falling edge.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    exp_t e;
    e.cyc    = cyc + LAT;
    e.is_err = !stop;
    e.data   = stop ? b : last_good;
    sb_q.push_back(e);
    if (stop) last_good = b;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_data(input string name, input logic [7:0] req);
    checks = checks + 1;
    if (out_data !== req) begin
      errors = errors + 1;
      $display("FAIL %s: out_data=0x%02h, required 0x%02h", name, out_data, req);
    end else begin
      $display("CHECK %s: out_data=0x%02h", name, out_data);
    end
  endtask

  task automatic check_drained(input string name);
    for (int i = 0; i < 4 * CPB && sb_q.size() != 0; i++) @(negedge clk);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s: %0d expected strobes missing, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    logic [7:0] mid;
    checks    = 0;
    errors    = 0;
    last_good = 8'h00;
    rst_n     = 1'b0;
    rx        = 1'b1;

    // 1. Reset values, then 500 quiet cycles (the monitor flags any strobe).
    repeat (5) @(negedge clk);
    check_data("reset_data", 8'h00);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    check_data("idle_data", 8'h00);

    // 2. Single byte.
    send_frame(8'h55, 1'b1);
    check_drained("single_byte");
    repeat (2 * CPB) @(negedge clk);

    // 3. Back-to-back bytes, no idle gap (160 cycles apart).
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    check_drained("back_to_back");
    repeat (2 * CPB) @(negedge clk);

    // 4. Five-cycle glitch, then a real byte.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_data("after_glitch", 8'hFF);
    send_frame(8'h3C, 1'b1);
    check_drained("glitch_then_byte");
    repeat (2 * CPB) @(negedge clk);

    // 5. Stop bit low, line held low 20 bit times, then a good byte.
    send_frame(8'h81, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    rx = 1'b1;
    check_drained("frame_err");
    check_data("hold_after_err", 8'h3C);
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h7E, 1'b1);
    check_drained("after_break");
    repeat (2 * CPB) @(negedge clk);

    // 6. Reset during data bit 4 of 0xC9, then 0x12.
    mid = 8'hC9;
    rx  = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = mid[i];
      repeat (CPB) @(negedge clk);
    end
    rx = mid[4];
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    last_good = 8'h00;
    repeat (4) @(negedge clk);
    check_data("mid_frame_reset", 8'h00);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check_data("after_reset_release", 8'h00);
    send_frame(8'h12, 1'b1);
    check_drained("after_reset_byte");
    repeat (2 * CPB) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
